// File: rtl/spi_chain_master.sv
// -----------------------------------------------------------------------------
// spi_chain_master
//   SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, 8 bits per byte. It turns a
//   valid/ready byte stream into full-duplex SPI transfers. Chip-select stays
//   low across consecutive bytes until a byte flagged LAST has completed.
//
// Parameters
//   CLK_DIV   SCLK half-period in iCLK cycles (2..255)
//   CS_SETUP  iCLK cycles from CSn falling to the first SCLK low phase (>=1)
//   CS_HOLD   iCLK cycles from the final SCLK fall to CSn rising (>=1)
//
// Ports
//   iCLK, iRESETn          clock, asynchronous active-low reset
//   iTX_DATA/LAST/VALID    byte offer; taken when iTX_VALID && oTX_READY
//   oTX_READY              high only in IDLE and WAIT
//   oRX_DATA, oRX_VALID    received byte, one-cycle valid pulse
//   oBUSY                  high whenever the FSM is not IDLE
//   oSPI_SCLK/MOSI/CSn     SPI outputs (all registered)
//   iSPI_MISO              SPI input (not synchronised; CLK_DIV>=2 gives margin)
// -----------------------------------------------------------------------------
module spi_chain_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic [7:0] iTX_DATA,
    input  logic       iTX_LAST,
    input  logic       iTX_VALID,
    output logic       oTX_READY,
    output logic [7:0] oRX_DATA,
    output logic       oRX_VALID,
    output logic       oBUSY,
    output logic       oSPI_SCLK,
    output logic       oSPI_MOSI,
    input  logic       iSPI_MISO,
    output logic       oSPI_CSn
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);

    state_t     state_q;
    logic [7:0] div_q;
    logic [2:0] bit_q;
    logic [7:0] tx_sh_q;
    logic [7:0] rx_sh_q;
    logic       last_q;
    logic       cs_n_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       ready_q;
    logic       busy_q;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            last_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // ready_q is 0 straight out of reset, so the first cycle
                    // after release never accepts a byte.
                    cs_n_q  <= 1'b1;
                    ready_q <= 1'b1;
                    if (iTX_VALID && ready_q) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        cs_n_q  <= 1'b0;
                        mosi_q  <= iTX_DATA[7];
                        tx_sh_q <= iTX_DATA;
                        last_q  <= iTX_LAST;
                        div_q   <= SETUP_LOAD;
                    end
                end

                ST_SETUP: begin
                    if (div_q == '0) begin
                        state_q <= ST_SHIFT;
                        div_q   <= DIV_LOAD;
                        bit_q   <= '0;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end

                ST_SHIFT: begin
                    if (div_q != '0) begin
                        div_q <= div_q - 8'd1;
                    end else begin
                        div_q <= DIV_LOAD;
                        if (!sclk_q) begin
                            // Rising edge: sample MISO at the end of the low phase.
                            sclk_q  <= 1'b1;
                            rx_sh_q <= {rx_sh_q[6:0], iSPI_MISO};
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                // Byte complete; the end-of-byte cycle is
                                // already the first HOLD (or WAIT) cycle.
                                rx_data_q  <= rx_sh_q;
                                rx_valid_q <= 1'b1;
                                if (last_q) begin
                                    state_q <= ST_HOLD;
                                    div_q   <= HOLD_LOAD;
                                end else begin
                                    state_q <= ST_WAIT;
                                    ready_q <= 1'b1;
                                end
                            end else begin
                                mosi_q  <= tx_sh_q[6];
                                tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                            end
                        end
                    end
                end

                ST_WAIT: begin
                    if (iTX_VALID && ready_q) begin
                        state_q <= ST_SHIFT;
                        ready_q <= 1'b0;
                        mosi_q  <= iTX_DATA[7];
                        tx_sh_q <= iTX_DATA;
                        last_q  <= iTX_LAST;
                        div_q   <= DIV_LOAD;
                        bit_q   <= '0;
                    end
                end

                ST_HOLD: begin
                    if (div_q == '0) begin
                        state_q <= ST_IDLE;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign oTX_READY = ready_q;
    assign oRX_DATA  = rx_data_q;
    assign oRX_VALID = rx_valid_q;
    assign oBUSY     = busy_q;
    assign oSPI_SCLK = sclk_q;
    assign oSPI_MOSI = mosi_q;
    assign oSPI_CSn  = cs_n_q;

endmodule

// File: tb/tb_spi_chain_master.sv
module tb_spi_chain_master;

    logic       clk;
    logic       rstn;
    logic [7:0] tx_data;
    logic       tx_last;

    // Instance with CLK_DIV=2
    logic       valid0, ready0, rxv0, busy0, sclk0, mosi0, miso0, csn0;
    logic [7:0] rxd0;
    // Instance with CLK_DIV=5
    logic       valid5, ready5, rxv5, busy5, sclk5, mosi5, csn5;
    logic [7:0] rxd5;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t q0[$];
    exp_t q5[$];

    // Mode-0 slave model for instance 0
    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    bit         loopback = 1'b0;

    // Edge trackers (sampled on negedge iCLK)
    int  rise_cnt = 0, first_rise = 0, cs_low_cnt = 0, cs_first_low = 0;
    int  cs_rise_cnt = 0, cs_rise_cyc = 0;
    int  r5n = 0, r5a = 0, r5b = 0, f5n = 0, f5a = 0;
    logic psclk = 1'b0, pcs = 1'b1, ps5 = 1'b0;

    spi_chain_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) u_dut (
        .iCLK(clk), .iRESETn(rstn),
        .iTX_DATA(tx_data), .iTX_LAST(tx_last), .iTX_VALID(valid0),
        .oTX_READY(ready0), .oRX_DATA(rxd0), .oRX_VALID(rxv0), .oBUSY(busy0),
        .oSPI_SCLK(sclk0), .oSPI_MOSI(mosi0), .iSPI_MISO(miso0), .oSPI_CSn(csn0)
    );

    spi_chain_master #(.CLK_DIV(5), .CS_SETUP(2), .CS_HOLD(2)) u_dut5 (
        .iCLK(clk), .iRESETn(rstn),
        .iTX_DATA(tx_data), .iTX_LAST(tx_last), .iTX_VALID(valid5),
        .oTX_READY(ready5), .oRX_DATA(rxd5), .oRX_VALID(rxv5), .oBUSY(busy5),
        .oSPI_SCLK(sclk5), .oSPI_MOSI(mosi5), .iSPI_MISO(mosi5), .oSPI_CSn(csn5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    assign miso0 = loopback ? mosi0 : slv_tx[7];
    always @(posedge sclk0) slv_rx <= {slv_rx[6:0], mosi0};
    always @(negedge sclk0) slv_tx <= {slv_tx[6:0], 1'b0};

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sclk0 && !psclk) begin
            if (rise_cnt == 0) first_rise = cyc;
            rise_cnt = rise_cnt + 1;
        end
        if (!csn0) begin
            if (cs_low_cnt == 0) cs_first_low = cyc;
            cs_low_cnt = cs_low_cnt + 1;
        end
        if (csn0 && !pcs) begin
            cs_rise_cnt = cs_rise_cnt + 1;
            cs_rise_cyc = cyc;
        end
        if (sclk5 && !ps5) begin
            if (r5n == 0) r5a = cyc;
            else if (r5n == 1) r5b = cyc;
            r5n = r5n + 1;
        end
        if (!sclk5 && ps5 && f5n == 0) begin
            f5a = cyc;
            f5n = 1;
        end
        psclk = sclk0;
        pcs   = csn0;
        ps5   = sclk5;
    end

    // Scoreboard monitors
    always @(negedge clk) begin
        if (rxv0) begin
            if (q0.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL rx0_spurious: got data 0x%0h at cycle %0d, expected no pulse", rxd0, cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("rx0_data", rxd0, e.d);
                chk("rx0_cycle", cyc, e.c);
            end
        end
    end

    always @(negedge clk) begin
        if (rxv5) begin
            if (q5.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL rx5_spurious: got data 0x%0h at cycle %0d, expected no pulse", rxd5, cyc);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("rx5_data", rxd5, e.d);
                chk("rx5_cycle", cyc, e.c);
            end
        end
    end

    // Offer a byte; accept cycle A is the cycle whose closing edge sees valid&&ready.
    task automatic send(input bit sel, input logic [7:0] d, input bit l, input bit hold,
                        input bit exp_en, input logic [7:0] exp_d, input int dly,
                        output int a);
        bit ok = 1'b0;
        a = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            tx_data = d;
            tx_last = l;
            if (sel) valid5 = 1'b1; else valid0 = 1'b1;
            if (sel ? ready5 : ready0) begin
                ok = 1'b1;
                a  = cyc;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else if (exp_en) begin
            exp_t e;
            e.d = exp_d;
            e.c = a + dly;
            if (sel) q5.push_back(e); else q0.push_back(e);
        end
        @(negedge clk);
        if (!hold) begin
            if (sel) valid5 = 1'b0; else valid0 = 1'b0;
        end
    endtask

    task automatic clr_track();
        rise_cnt    = 0;
        cs_low_cnt  = 0;
        cs_rise_cnt = 0;
    endtask

    initial begin
        int  a, a2;
        bit  bad;
        rstn    = 1'b0;
        tx_data = 8'h00;
        tx_last = 1'b0;
        valid0  = 1'b0;
        valid5  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_csn", csn0, 1);
        chk("rst_sclk", sclk0, 0);
        chk("rst_mosi", mosi0, 0);
        chk("rst_ready", ready0, 0);
        chk("rst_rxv", rxv0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_rxd", rxd0, 8'h00);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_release", ready0, 1);
        repeat (2) @(negedge clk);
        clr_track();

        // Single byte 0xA5 with LAST, slave returns 0x3C
        loopback = 1'b0;
        slv_tx   = 8'h3C;
        send(0, 8'hA5, 1, 0, 1, 8'h3C, 35, a);
        chk("t1_busy", busy0, 1);
        repeat (50) @(negedge clk);
        chk("t1_mosi_bits", slv_rx, 8'hA5);
        chk("t1_rises", rise_cnt, 8);
        chk("t1_cs_low_cycles", cs_low_cnt, 36);
        chk("t1_cs_first_low", cs_first_low, a + 1);
        chk("t1_cs_rise", cs_rise_cyc, a + 37);
        chk("t1_busy_end", busy0, 0);

        // Burst 0x01,0x02,0x03 with VALID held, loopback
        clr_track();
        loopback = 1'b1;
        send(0, 8'h01, 0, 1, 1, 8'h01, 35, a);
        send(0, 8'h02, 0, 1, 1, 8'h02, 33, a);
        send(0, 8'h03, 1, 0, 1, 8'h03, 33, a);
        repeat (50) @(negedge clk);
        chk("t2_rises", rise_cnt, 24);
        chk("t2_cs_rises", cs_rise_cnt, 1);

        // WAIT stall
        clr_track();
        loopback = 1'b0;
        slv_tx   = 8'h81;
        send(0, 8'h55, 0, 0, 1, 8'h81, 35, a);
        repeat (36) @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (csn0 !== 1'b0 || sclk0 !== 1'b0 || ready0 !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        chk("t3_wait_stable", bad, 0);
        rise_cnt = 0;
        slv_tx   = 8'h7E;
        send(0, 8'hAA, 1, 0, 1, 8'h7E, 33, a2);
        repeat (50) @(negedge clk);
        chk("t3_first_rise", first_rise, a2 + 3);
        chk("t3_cs_rises", cs_rise_cnt, 1);

        // Reset mid-byte
        clr_track();
        loopback = 1'b1;
        send(0, 8'hC3, 1, 0, 0, 8'h00, 0, a);
        for (int i = 0; i < 200 && rise_cnt < 4; i++) @(negedge clk);
        chk("t4_rise4", rise_cnt, 4);
        #1 rstn = 1'b0;
        #1;
        chk("t4_async_csn", csn0, 1);
        chk("t4_async_sclk", sclk0, 0);
        chk("t4_async_ready", ready0, 0);
        chk("t4_async_busy", busy0, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        clr_track();
        send(0, 8'h5A, 1, 0, 1, 8'h5A, 35, a);
        repeat (50) @(negedge clk);
        chk("t4_clean_rises", rise_cnt, 8);
        chk("t4_clean_cs_low", cs_low_cnt, 36);

        // Ignored offer during SHIFT
        clr_track();
        loopback = 1'b0;
        slv_tx   = 8'h96;
        send(0, 8'h3C, 1, 0, 1, 8'h96, 35, a);
        for (int i = 0; i < 100 && rise_cnt < 2; i++) @(negedge clk);
        bad = 1'b0;
        tx_data = 8'hFF;
        tx_last = 1'b0;
        valid0  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready0 !== 1'b0) bad = 1'b1;
        end
        valid0 = 1'b0;
        chk("t5_ready_low", bad, 0);
        repeat (50) @(negedge clk);
        chk("t5_mosi_bits", slv_rx, 8'h3C);
        chk("t5_rises", rise_cnt, 8);
        chk("t5_cs_low", cs_low_cnt, 36);

        // Divider CLK_DIV=5, loopback
        send(1, 8'hB4, 1, 0, 1, 8'hB4, 83, a);
        repeat (100) @(negedge clk);
        chk("t6_high_len", f5a - r5a, 5);
        chk("t6_period", r5b - r5a, 10);

        chk("q0_drained", q0.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
